// File: rtl/nanosoc_exp_region_mux_if.sv
// Expansion-region AHB bundle: initiator-facing signals (suffix S) and per-slot
// accelerator-facing signals (suffix M), with HRDATAM packed 32 bits per slot.
interface nanosoc_exp_region_mux_if #(
    parameter int ADDRWIDTH = 29,
    parameter int NUM_SLOTS = 4
);
    logic                     HSELS;
    logic [ADDRWIDTH-1:0]     HADDRS;
    logic [1:0]               HTRANSS;
    logic                     HREADYS;
    logic                     HREADYOUTS;
    logic                     HRESPS;
    logic [31:0]              HRDATAS;
    logic [NUM_SLOTS-1:0]     HSELM;
    logic [NUM_SLOTS-1:0]     HREADYOUTM;
    logic [NUM_SLOTS-1:0]     HRESPM;
    logic [32*NUM_SLOTS-1:0]  HRDATAM;

    // The mux is a target towards the initiator and a decoder towards the slots.
    modport slave (
        input  HSELS, HADDRS, HTRANSS, HREADYS, HREADYOUTM, HRESPM, HRDATAM,
        output HREADYOUTS, HRESPS, HRDATAS, HSELM
    );
    modport master (
        output HSELS, HADDRS, HTRANSS, HREADYS, HREADYOUTM, HRESPM, HRDATAM,
        input  HREADYOUTS, HRESPS, HRDATAS, HSELM
    );
endinterface

// File: rtl/nanosoc_exp_region_mux.sv
// Expansion-region decoder/response mux: NUM_SLOTS equal windows, a two-cycle
// ERROR default target and a per-slot HREADYOUT watchdog with sticky fault fencing.
module nanosoc_exp_region_mux #(
    parameter int                   ADDRWIDTH      = 29,
    parameter int                   SLOT_ADDRWIDTH = 12,
    parameter logic [ADDRWIDTH-1:0] BASE_ADDR      = 29'h0001_0000,
    parameter int                   NUM_SLOTS      = 4,
    parameter int                   TIMEOUT        = 1024
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    nanosoc_exp_region_mux_if.slave bus,
    output logic [NUM_SLOTS-1:0]    SLOT_FAULT,
    input  logic [NUM_SLOTS-1:0]    FAULT_CLR
);
    localparam int OFFW  = ADDRWIDTH - SLOT_ADDRWIDTH;
    localparam int SIDXW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TMRW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [OFFW-1:0] BASE_SLOT = BASE_ADDR[ADDRWIDTH-1:SLOT_ADDRWIDTH];
    localparam logic [TMRW-1:0] TMR_LAST  = TMRW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SLOT, ST_ERR1, ST_ERR2} state_t;

    state_t               state_q, state_d;
    logic [SIDXW-1:0]     sidx_q, sidx_d;
    logic [TMRW-1:0]      tmr_q, tmr_d;
    logic [NUM_SLOTS-1:0] fault_q, fault_d;

    logic [OFFW-1:0]      off;
    logic                 hit, tgt_faulted, accept, eval_next;
    logic [NUM_SLOTS-1:0] dec_onehot;
    logic [SIDXW-1:0]     dec_idx;
    logic                 sl_ready, sl_resp;
    logic [31:0]          sl_rdata;
    logic                 unused_addr_lsbs;

    function automatic logic [TMRW-1:0] tmr_sat_inc(input logic [TMRW-1:0] t);
        return (t == {TMRW{1'b1}}) ? t : t + TMRW'(1);
    endfunction

    // Unsigned subtraction wraps addresses below BASE_ADDR to huge offsets -> miss.
    always_comb begin
        off        = bus.HADDRS[ADDRWIDTH-1:SLOT_ADDRWIDTH] - BASE_SLOT;
        hit        = (off < OFFW'(NUM_SLOTS));
        dec_onehot = '0;
        dec_idx    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit && (off == OFFW'(i))) begin
                dec_onehot[i] = 1'b1;
                dec_idx       = SIDXW'(i);
            end
        end
        tgt_faulted = |(dec_onehot & fault_q);
        accept      = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
    end

    assign bus.HSELM      = HRESET ? '0 : (dec_onehot & ~fault_q & {NUM_SLOTS{bus.HSELS}});
    assign unused_addr_lsbs = ^{bus.HADDRS[SLOT_ADDRWIDTH-1:0], bus.HTRANSS[0]};

    always_comb begin
        sl_ready = 1'b1;
        sl_resp  = 1'b0;
        sl_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (sidx_q == SIDXW'(i)) begin
                sl_ready = bus.HREADYOUTM[i];
                sl_resp  = bus.HRESPM[i];
                sl_rdata = bus.HRDATAM[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sidx_d    = sidx_q;
        tmr_d     = tmr_q;
        fault_d   = fault_q & ~FAULT_CLR;
        eval_next = 1'b0;
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
            ST_SLOT: begin
                if (sl_ready) begin
                    eval_next = 1'b1;
                end else begin
                    tmr_d = tmr_sat_inc(tmr_q);
                    // A set in the same cycle as FAULT_CLR must win, so it is OR-ed last.
                    if ((TIMEOUT != 0) && (tmr_q == TMR_LAST)) begin
                        state_d = ST_ERR1;
                        for (int i = 0; i < NUM_SLOTS; i++)
                            if (sidx_q == SIDXW'(i)) fault_d[i] = 1'b1;
                    end
                end
            end
            default: eval_next = bus.HREADYS;
        endcase
        if (eval_next) begin
            if (accept && hit && !tgt_faulted) begin
                state_d = ST_SLOT;
                sidx_d  = dec_idx;
                tmr_d   = '0;
            end else if (accept) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            sidx_q  <= '0;
            tmr_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            tmr_q   <= tmr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        bus.HREADYOUTS = 1'b1;
        bus.HRESPS     = 1'b0;
        bus.HRDATAS    = '0;
        case (state_q)
            ST_SLOT: begin
                bus.HREADYOUTS = sl_ready;
                bus.HRESPS     = sl_resp;
                bus.HRDATAS    = sl_rdata;
            end
            ST_ERR1: begin
                bus.HREADYOUTS = 1'b0;
                bus.HRESPS     = 1'b1;
            end
            ST_ERR2: bus.HRESPS = 1'b1;
            default: ;
        endcase
    end

    assign SLOT_FAULT = fault_q;
endmodule

// File: tb/tb_nanosoc_exp_region_mux.sv
// Bench for nanosoc_exp_region_mux: decode table, directed multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
module tb_nanosoc_exp_region_mux;
    localparam int AW   = 29;
    localparam int NS   = 4;
    localparam int TO   = 16;
    localparam int BASE = 32'h0001_0000;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [NS-1:0] SLOT_FAULT;
    logic [NS-1:0] FAULT_CLR;

    nanosoc_exp_region_mux_if #(.ADDRWIDTH(AW), .NUM_SLOTS(NS)) bif ();

    nanosoc_exp_region_mux #(
        .ADDRWIDTH(AW), .SLOT_ADDRWIDTH(12), .BASE_ADDR(29'h0001_0000),
        .NUM_SLOTS(NS), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bif.slave),
        .SLOT_FAULT(SLOT_FAULT), .FAULT_CLR(FAULT_CLR)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_resp(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
        chk({tag, ".rdy"},  bif.HREADYOUTS, rdy);
        chk({tag, ".resp"}, bif.HRESPS, rsp);
        chk({tag, ".data"}, bif.HRDATAS, dat);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [AW-1:0] a, input logic [1:0] tr, input logic rdy);
        bif.HSELS   = sel;
        bif.HADDRS  = a;
        bif.HTRANSS = tr;
        bif.HREADYS = rdy;
    endtask

    task automatic set_slot(input int i, input logic r, input logic [31:0] d);
        bif.HREADYOUTM[i]         = r;
        bif.HRDATAM[32*i +: 32]   = d;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          sel;
        logic [NS-1:0] exp_sel;
    } dec_vec_t;
    dec_vec_t vt[10];

    // Reference model: outstanding data phase kind, owning slot, waits so far, fault flags.
    int            m_ph;  // 0 none, 1 slot, 2 error first cycle, 3 error second cycle
    int            m_s, m_w;
    logic [NS-1:0] m_f;

    function automatic int m_off(input logic [AW-1:0] a);
        return int'(a >> 12) - (BASE >> 12);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time budget exhausted");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{29'h0001_0004, 1'b1, 4'b0001};
        vt[1] = '{29'h0001_1FFC, 1'b1, 4'b0010};
        vt[2] = '{29'h0001_2000, 1'b1, 4'b0100};
        vt[3] = '{29'h0001_3000, 1'b1, 4'b1000};
        vt[4] = '{29'h0001_3FFF, 1'b1, 4'b1000};
        vt[5] = '{29'h0001_4000, 1'b1, 4'b0000};
        vt[6] = '{29'h0000_F000, 1'b1, 4'b0000};
        vt[7] = '{29'h1FFF_F000, 1'b1, 4'b0000};
        vt[8] = '{29'h0001_0000, 1'b0, 4'b0000};
        vt[9] = '{29'h0000_0000, 1'b1, 4'b0000};

        HRESET = 1'b1;
        FAULT_CLR = '0;
        bif.HRESPM = '0;
        bif.HREADYOUTM = '1;
        bif.HRDATAM = '0;
        drive(1'b1, 29'h0001_0000, 2'b10, 1'b1);
        tick();
        #4;
        chk("rst.hselm", bif.HSELM, 4'b0000);
        chk_resp("rst", 1'b1, 1'b0, 32'h0);
        chk("rst.fault", SLOT_FAULT, 4'b0000);
        tick();
        HRESET = 1'b0;
        drive(1'b0, '0, 2'b00, 1'b1);

        // Decode table: HREADYS low so nothing is accepted, only the decoder is seen.
        for (int i = 0; i < 10; i++) begin
            tick();
            drive(vt[i].sel, vt[i].addr, 2'b10, 1'b0);
            #4;
            chk($sformatf("dec%0d.hselm", i), bif.HSELM, vt[i].exp_sel);
            chk_resp($sformatf("dec%0d", i), 1'b1, 1'b0, 32'h0);
        end

        // Single read to slot0.
        tick();
        set_slot(0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b1, 29'h0001_0004, 2'b10, 1'b1);
        #4; chk("rd0.hselm", bif.HSELM, 4'b0001);
        tick();
        drive(1'b0, '0, 2'b00, 1'b1);
        #4; chk_resp("rd0", 1'b1, 1'b0, 32'hDEAD_BEEF);

        // Slot3 routing.
        tick();
        set_slot(3, 1'b1, 32'h3333_1234);
        drive(1'b1, 29'h0001_3000, 2'b10, 1'b1);
        #4; chk("rd3.hselm", bif.HSELM, 4'b1000);
        tick();
        drive(1'b0, '0, 2'b00, 1'b1);
        #4; chk_resp("rd3", 1'b1, 1'b0, 32'h3333_1234);

        // Misses above and below the region hit the default ERROR target.
        for (int k = 0; k < 2; k++) begin
            tick();
            drive(1'b1, (k == 0) ? 29'h0001_4000 : 29'h0000_F000, 2'b10, 1'b1);
            #4; chk($sformatf("miss%0d.hselm", k), bif.HSELM, 4'b0000);
            tick();
            drive(1'b0, '0, 2'b00, 1'b0);
            #4; chk_resp($sformatf("miss%0d.e1", k), 1'b0, 1'b1, 32'h0);
            tick();
            bif.HREADYS = 1'b1;
            #4; chk_resp($sformatf("miss%0d.e2", k), 1'b1, 1'b1, 32'h0);
        end

        // Hung slot1: TIMEOUT waits, ERR1, ERR2, then fenced.
        tick();
        set_slot(1, 1'b0, 32'h1111_0000);
        drive(1'b1, 29'h0001_1000, 2'b10, 1'b1);
        #4; chk("to.hselm", bif.HSELM, 4'b0010);
        for (int k = 0; k < TO; k++) begin
            tick();
            drive(1'b0, '0, 2'b00, 1'b0);
            #4;
            chk($sformatf("to.wait%0d.rdy", k), bif.HREADYOUTS, 1'b0);
            chk($sformatf("to.wait%0d.resp", k), bif.HRESPS, 1'b0);
        end
        tick();
        #4;
        chk_resp("to.e1", 1'b0, 1'b1, 32'h0);
        chk("to.fault", SLOT_FAULT, 4'b0010);
        tick();
        drive(1'b1, 29'h0001_1000, 2'b10, 1'b1);
        #4;
        chk_resp("to.e2", 1'b1, 1'b1, 32'h0);
        chk("fenced.hselm", bif.HSELM, 4'b0000);
        tick();
        drive(1'b0, '0, 2'b00, 1'b0);
        #4; chk_resp("fenced.e1", 1'b0, 1'b1, 32'h0);
        tick();
        bif.HREADYS = 1'b1;
        #4; chk_resp("fenced.e2", 1'b1, 1'b1, 32'h0);
        tick();
        FAULT_CLR = 4'b0010;
        tick();
        FAULT_CLR = '0;
        #4; chk("clr.fault", SLOT_FAULT, 4'b0000);
        tick();
        set_slot(1, 1'b1, 32'h1111_ABCD);
        drive(1'b1, 29'h0001_1008, 2'b10, 1'b1);
        #4; chk("clr.hselm", bif.HSELM, 4'b0010);
        tick();
        drive(1'b0, '0, 2'b00, 1'b1);
        #4; chk_resp("clr.rd", 1'b1, 1'b0, 32'h1111_ABCD);

        // Pipelined: slot0 with two waits, slot2 address held until HREADYS.
        tick();
        set_slot(0, 1'b1, 32'hA0A0_0000);
        set_slot(2, 1'b1, 32'hB2B2_2222);
        drive(1'b1, 29'h0001_0010, 2'b10, 1'b1);
        #4; chk("pipe.a0.hselm", bif.HSELM, 4'b0001);
        for (int k = 0; k < 2; k++) begin
            tick();
            set_slot(0, 1'b0, 32'hA0A0_0000);
            drive(1'b1, 29'h0001_2010, 2'b10, 1'b0);
            #4;
            chk($sformatf("pipe.w%0d.rdy", k), bif.HREADYOUTS, 1'b0);
            chk($sformatf("pipe.w%0d.hselm", k), bif.HSELM, 4'b0100);
        end
        tick();
        set_slot(0, 1'b1, 32'hA0A0_0000);
        bif.HREADYS = 1'b1;
        #4; chk_resp("pipe.d0", 1'b1, 1'b0, 32'hA0A0_0000);
        tick();
        drive(1'b0, '0, 2'b00, 1'b1);
        #4; chk_resp("pipe.d2", 1'b1, 1'b0, 32'hB2B2_2222);
        tick();
        #4; chk_resp("pipe.idle", 1'b1, 1'b0, 32'h0);

        // Clear pulse coinciding with the timeout: set wins.
        tick();
        set_slot(1, 1'b0, 32'h0);
        drive(1'b1, 29'h0001_1000, 2'b10, 1'b1);
        for (int k = 0; k < TO; k++) begin
            tick();
            drive(1'b0, '0, 2'b00, 1'b0);
            FAULT_CLR = (k == TO - 1) ? 4'b0010 : 4'b0000;
        end
        tick();
        FAULT_CLR = '0;
        #4;
        chk("setwins.fault", SLOT_FAULT, 4'b0010);
        chk_resp("setwins.e1", 1'b0, 1'b1, 32'h0);
        tick();
        bif.HREADYS = 1'b1;

        // Reset in the middle of a slot2 wait.
        tick();
        set_slot(2, 1'b0, 32'h2222_0000);
        drive(1'b1, 29'h0001_2000, 2'b10, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            drive(1'b0, '0, 2'b00, 1'b0);
        end
        tick();
        HRESET = 1'b1;
        drive(1'b1, 29'h0001_0000, 2'b00, 1'b0);
        #4; chk("rstmid.hselm", bif.HSELM, 4'b0000);
        tick();
        HRESET = 1'b0;
        drive(1'b0, '0, 2'b00, 1'b1);
        #4;
        chk_resp("rstmid", 1'b1, 1'b0, 32'h0);
        chk("rstmid.fault", SLOT_FAULT, 4'b0000);

        // Randomized traffic against the reference model.
        begin
            logic [NS-1:0] stuck, rdy_v, rsp_v, clr_v, nf;
            logic          rst_v, sel_v, e_rdy, e_rsp, take;
            logic [1:0]    tr_v;
            logic [AW-1:0] a_v;
            logic [31:0]   dat_v[NS];
            logic [31:0]   e_dat;
            logic [NS-1:0] e_sel;
            int            off, nph;
            bit            hit;
            m_ph = 0; m_s = 0; m_w = 0; m_f = '0;
            stuck = '0;
            for (int c = 0; c < 800; c++) begin
                tick();
                rst_v = ($urandom_range(0, 199) == 0);
                sel_v = ($urandom_range(0, 7) != 0);
                tr_v  = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: a_v = AW'(BASE + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 1023) << 2));
                    6: a_v = AW'(32'h0001_4000 + ($urandom_range(0, 3) << 12));
                    7: a_v = AW'(32'h0000_F000 + $urandom_range(0, 4095));
                    default: a_v = AW'($urandom);
                endcase
                for (int i = 0; i < NS; i++) begin
                    if ($urandom_range(0, 59) == 0) stuck[i] = ~stuck[i];
                    rdy_v[i] = !stuck[i] && ($urandom_range(0, 3) != 0);
                    rsp_v[i] = ($urandom_range(0, 15) == 0);
                    clr_v[i] = ($urandom_range(0, 31) == 0);
                    dat_v[i] = $urandom;
                    set_slot(i, rdy_v[i], dat_v[i]);
                end
                bif.HRESPM = rsp_v;
                FAULT_CLR  = clr_v;
                HRESET     = rst_v;

                off = m_off(a_v);
                hit = (off >= 0) && (off < NS);
                case (m_ph)
                    1: begin e_rdy = rdy_v[m_s]; e_rsp = rsp_v[m_s]; e_dat = dat_v[m_s]; end
                    2: begin e_rdy = 1'b0; e_rsp = 1'b1; e_dat = '0; end
                    3: begin e_rdy = 1'b1; e_rsp = 1'b1; e_dat = '0; end
                    default: begin e_rdy = 1'b1; e_rsp = 1'b0; e_dat = '0; end
                endcase
                e_sel = '0;
                if (!rst_v && sel_v && hit && !m_f[off]) e_sel[off] = 1'b1;
                drive(sel_v, a_v, tr_v, e_rdy);
                #4;
                chk("rnd.hselm", bif.HSELM, e_sel);
                chk("rnd.rdy", bif.HREADYOUTS, e_rdy);
                chk("rnd.resp", bif.HRESPS, e_rsp);
                chk("rnd.data", bif.HRDATAS, e_dat);
                chk("rnd.fault", SLOT_FAULT, m_f);

                if (rst_v) begin
                    m_ph = 0; m_s = 0; m_w = 0; m_f = '0;
                end else begin
                    nf   = m_f & ~clr_v;
                    nph  = m_ph;
                    take = 1'b0;
                    case (m_ph)
                        2: nph = 3;
                        1: begin
                            if (rdy_v[m_s]) take = 1'b1;
                            else begin
                                m_w++;
                                if (m_w == TO) begin nph = 2; nf[m_s] = 1'b1; end
                            end
                        end
                        default: take = 1'b1;
                    endcase
                    if (take) begin
                        if (sel_v && tr_v[1] && hit && !m_f[off]) begin
                            nph = 1; m_s = off; m_w = 0;
                        end else if (sel_v && tr_v[1]) nph = 2;
                        else nph = 0;
                    end
                    m_ph = nph;
                    m_f  = nf;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
